// File: rtl/counter_cmd_arbiter_pkg.sv
// Shared types for the 4-bit clear/plus counter controller: counter width,
// command encoding and controller FSM states.
package counter_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    OP_INCR  = 1'b0,
    OP_CLEAR = 1'b1
  } cnt_op_e;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } ctrl_state_e;

endpackage : counter_ctrl_pkg

// File: rtl/counter_cmd_arbiter_if.sv
// Requester-side bus of the counter command arbiter: request/op levels in,
// one-hot grant pulse and a one-cycle response strobe with payload out.
interface counter_cmd_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  import counter_ctrl_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] op;
  logic [NUM_REQ-1:0] gnt;
  logic               rsp_valid;
  logic [IDX_W-1:0]   rsp_id;
  logic [CNT_W-1:0]   rsp_value;
  logic               rsp_wrap;

  // Requesters drive req/op and observe grant and response.
  modport master (
    output req, op,
    input  gnt, rsp_valid, rsp_id, rsp_value, rsp_wrap
  );

  // The arbiter samples req/op and drives grant and response.
  modport slave (
    input  req, op,
    output gnt, rsp_valid, rsp_id, rsp_value, rsp_wrap
  );

endinterface : counter_cmd_arbiter_if

// File: rtl/counter_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, searching cyclically.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] cand_s;

  // Scan from the farthest offset down so the nearest match is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = {IDX_W{1'b0}};
    cand_s  = {IDX_W{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[cand_s]) begin
        found_o = 1'b1;
        idx_o   = cand_s;
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/counter_cmd_arbiter.sv
// Round-robin command arbiter/sequencer for the shared clear/plus counter.
// Owns power-on clearing of the (unreset) counter flops, grants one requester
// per 3-cycle command and returns the post-command counter value.
module counter_cmd_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  counter_cmd_arbiter_if.slave  bus,
  output logic                  clear_o,
  output logic                  plus_o,
  input  logic [CNT_W-1:0]      count_q_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  ctrl_state_e      state_q, state_d, state_s;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_q, win_d;
  cnt_op_e          op_q, op_d;
  logic [CNT_W-1:0] val_q, val_d;

  logic             arb_found_s;
  logic [IDX_W-1:0] arb_idx_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .found_o (arb_found_s),
    .idx_o   (arb_idx_s)
  );

  // State, pointer and captured command registers; reset restarts at INIT.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= INIT;
      ptr_q   <= {IDX_W{1'b0}};
      win_q   <= {IDX_W{1'b0}};
      op_q    <= OP_INCR;
      val_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      val_q   <= val_d;
    end
  end

  // Next-state logic: capture the winner in IDLE, advance pointer in ISSUE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    val_d   = val_q;
    case (state_q)
      INIT: state_d = IDLE;
      IDLE: begin
        if (arb_found_s) begin
          win_d   = arb_idx_s;
          op_d    = bus.op[arb_idx_s] ? OP_CLEAR : OP_INCR;
          val_d   = count_q_i;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (win_q == IDX_W'(NUM_REQ - 1)) begin
          ptr_d = {IDX_W{1'b0}};
        end else begin
          ptr_d = win_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // Output decode; a synchronous reset in flight suppresses the current
  // command's outputs immediately, so an aborted command never responds.
  always_comb begin
    state_s       = reset_i ? INIT : state_q;
    clear_o       = 1'b0;
    plus_o        = 1'b0;
    bus.gnt       = {NUM_REQ{1'b0}};
    bus.rsp_valid = 1'b0;
    bus.rsp_id    = {IDX_W{1'b0}};
    bus.rsp_value = {CNT_W{1'b0}};
    bus.rsp_wrap  = 1'b0;
    case (state_s)
      INIT: clear_o = 1'b1;
      IDLE: clear_o = 1'b0;
      ISSUE: begin
        bus.gnt = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_q;
        clear_o = (op_q == OP_CLEAR);
        plus_o  = (op_q == OP_INCR);
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_id    = win_q;
        bus.rsp_value = count_q_i;
        bus.rsp_wrap  = (op_q == OP_INCR) && (val_q == {CNT_W{1'b1}});
      end
      default: clear_o = 1'b1;
    endcase
  end

endmodule : counter_cmd_arbiter

// File: tb/tb_counter_cmd_arbiter.sv
// Directed bench for counter_cmd_arbiter with a behavioural clear/plus
// counter model standing in for the datapath.
module tb_counter_cmd_arbiter;
  import counter_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             clear, plus;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic [CNT_W-1:0] load_val;
  int               n_tests = 0;
  int               n_fail  = 0;

  counter_cmd_arbiter_if #(.NUM_REQ(4)) bus_if ();

  counter_cmd_arbiter #(.NUM_REQ(4)) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .bus       (bus_if),
    .clear_o   (clear),
    .plus_o    (plus),
    .count_q_i (cnt)
  );

  always #5 clk = ~clk;

  // Datapath model: clear has priority, bench preload stands in for history.
  always @(posedge clk) begin
    if (load)       cnt <= load_val;
    else if (clear) cnt <= 4'd0;
    else if (plus)  cnt <= cnt + 4'd1;
  end

  // clear and plus must never be active together.
  always @(negedge clk) begin
    n_tests++;
    assert ((clear & plus) === 1'b0) else begin
      n_fail++;
      $error("FAIL clr_plus_excl: observed clear=%b plus=%b required not both 1", clear, plus);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_val = 4'd0;
    bus_if.req = 4'b0000; bus_if.op = 4'b0000;
    tick(); tick();
    chk("rst_gnt", 32'(bus_if.gnt), 32'd0);
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("rst_plus", 32'(plus), 32'd0);

    // Reset release: one INIT clear cycle, then idle forever.
    reset = 1'b0;
    #1;
    chk("init_clear", 32'(clear), 32'd1);
    chk("init_gnt", 32'(bus_if.gnt), 32'd0);
    tick();
    chk("idle_clear", 32'(clear), 32'd0);
    chk("init_cnt_zero", 32'(cnt), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("idle_gnt", 32'(bus_if.gnt), 32'd0);
      chk("idle_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    end

    // Single increment on requester 2 from count 5.
    load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0; bus_if.req = 4'b0100; bus_if.op = 4'b0000;
    tick();
    chk("inc_gnt", 32'(bus_if.gnt), 32'h4);
    chk("inc_plus", 32'(plus), 32'd1);
    chk("inc_clear", 32'(clear), 32'd0);
    chk("inc_issue_rsp_value", 32'(bus_if.rsp_value), 32'd0);
    bus_if.req = 4'b0000;
    tick();
    chk("inc_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    chk("inc_rsp_id", 32'(bus_if.rsp_id), 32'd2);
    chk("inc_rsp_value", 32'(bus_if.rsp_value), 32'd6);
    chk("inc_rsp_wrap", 32'(bus_if.rsp_wrap), 32'd0);
    tick();
    chk("inc_after_rsp", 32'(bus_if.rsp_valid), 32'd0);

    // All four requesting increments: rotation 0,1,2,3,0 from count 0.
    do_reset();
    bus_if.req = 4'b1111; bus_if.op = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_gnt", 32'(bus_if.gnt), 32'(1 << (i % 4)));
      tick();
      chk("rr_rsp_id", 32'(bus_if.rsp_id), 32'(i % 4));
      chk("rr_rsp_value", 32'(bus_if.rsp_value), 32'(i + 1));
      if (i == 4) bus_if.req = 4'b0000;
      tick();
      chk("rr_idle_gnt", 32'(bus_if.gnt), 32'd0);
    end

    // 16 increments from 15: wrap flagged only on the first.
    load = 1'b1; load_val = 4'd15;
    tick();
    load = 1'b0; bus_if.req = 4'b0001; bus_if.op = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      tick();
      tick();
      chk("wrap_rsp_value", 32'(bus_if.rsp_value), 32'((i + 16) % 16));
      chk("wrap_rsp_wrap", 32'(bus_if.rsp_wrap), (i == 0) ? 32'd1 : 32'd0);
      if (i == 15) bus_if.req = 4'b0000;
      tick();
    end

    // Clear command from requester 1 at count 9.
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; bus_if.req = 4'b0010; bus_if.op = 4'b0010;
    tick();
    chk("clr_gnt", 32'(bus_if.gnt), 32'h2);
    chk("clr_clear", 32'(clear), 32'd1);
    chk("clr_plus", 32'(plus), 32'd0);
    bus_if.req = 4'b0000; bus_if.op = 4'b0000;
    tick();
    chk("clr_rsp_id", 32'(bus_if.rsp_id), 32'd1);
    chk("clr_rsp_value", 32'(bus_if.rsp_value), 32'd0);
    chk("clr_rsp_wrap", 32'(bus_if.rsp_wrap), 32'd0);
    tick();

    // Reset during RESP aborts the response; pointer returns to 0.
    bus_if.req = 4'b1000; bus_if.op = 4'b0000;
    tick();
    chk("abort_gnt", 32'(bus_if.gnt), 32'h8);
    bus_if.req = 4'b0011;
    tick();
    reset = 1'b1;
    #1;
    chk("abort_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("abort_rsp_value", 32'(bus_if.rsp_value), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("abort_init_clear", 32'(clear), 32'd1);
    chk("abort_init_gnt", 32'(bus_if.gnt), 32'd0);
    tick();
    chk("abort_idle_gnt", 32'(bus_if.gnt), 32'd0);
    tick();
    chk("abort_next_gnt", 32'(bus_if.gnt), 32'h1);
    bus_if.req = 4'b0000;
    tick();
    chk("abort_next_rsp_id", 32'(bus_if.rsp_id), 32'd0);
    chk("abort_next_rsp_value", 32'(bus_if.rsp_value), 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_counter_cmd_arbiter

// File: doc/counter_cmd_arbiter.md
# counter_cmd_arbiter

Round-robin command arbiter and sequencer for the shared 4-bit clear/plus counter datapath (four FDCE bits plus next-state mux). Collects increment/clear requests from up to `NUM_REQ` requesters, grants one at a time, and drives the datapath `clear`/`plus` controls for exactly one cycle per command. Reads back the counter value `Q` and returns it to the granted requester. The counter flops have no reset, so this block also owns power-on initialisation of the counter.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `CNT_W`, 4: counter width; must match the datapath.
- `clk`  in  1  single clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request level.
- `op`  in  NUM_REQ  per-requester operation: 0 = increment, 1 = clear. Sampled only with `req`.
- `gnt`  out  NUM_REQ  one-hot, one-cycle grant pulse.
- `clear`  out  1  datapath clear control.
- `plus`  out  1  datapath increment control.
- `count_q`  in  CNT_W  datapath `Q` feedback.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_id`  out  $clog2(NUM_REQ)  index of the requester being answered.
- `rsp_value`  out  CNT_W  counter value after the command.
- `rsp_wrap`  out  1  increment wrapped from all-ones to 0.

## Operation
- States: INIT, IDLE, ISSUE, RESP.
- Reset: state←INIT, rr pointer←0. All outputs are 0 except `clear`, which is 1 in INIT.
- INIT, one cycle: `clear`=1, `plus`=0, no `gnt`. Next state is IDLE.
- IDLE: if any `req`, pick the first asserted index at or after the rr pointer, cyclically. Register the winner index, its `op`, and `count_q`. Next state is ISSUE. If no `req`, remain in IDLE.
- ISSUE, one cycle:
  - `gnt[winner]`=1.
  - increment: `plus`=1, `clear`=0. clear: `clear`=1, `plus`=0.
  - `clear` and `plus` are never both 1.
  - rr pointer←(winner+1) mod NUM_REQ.
  - Next state is RESP.
- RESP, one cycle:
  - `rsp_valid`=1, `rsp_id`=winner, `rsp_value`=`count_q`.
  - `rsp_wrap`=1 iff op was increment and the value captured in IDLE was all-ones.
  - Next state is IDLE.
- Requester rules:
  - Hold `req` and `op` stable until `gnt`.
  - A `req` still high in the cycle after `gnt` counts as a new request.
  - Changes to `req` or `op` while the block is in ISSUE or RESP are ignored.
- Increment arithmetic is modulo 2^CNT_W. Clear yields 0 with `rsp_wrap`=0.
- `rsp_*` outputs are 0 whenever `rsp_valid`=0.

## Timing
- Command cycle is 3 cycles: IDLE sample (cycle n), ISSUE with `gnt`/control (n+1), RESP (n+2).
- Peak throughput is one command per 3 cycles. There are no back-to-back grants.
- Datapath latency: controls in cycle n+1, new `Q` valid in cycle n+2. `count_q` is sampled combinationally in RESP.
- First grant is possible 2 cycles after `reset` deasserts (INIT, then IDLE sample).
- Simultaneous requests: only the rr winner is granted. Losers stay pending and are served in later cycles in rotation, with no starvation: worst-case wait is NUM_REQ commands.
- Reset asserted mid-command, in ISSUE or RESP: next cycle is INIT. No `rsp_valid` for the aborted command, and the rr pointer returns to 0.
- Reset has priority over all other inputs.

## Structure
- Shared package `counter_ctrl_pkg`:
  - `CNT_W` constant.
  - `cnt_op_e` enum {OP_INCR, OP_CLEAR}.
  - `ctrl_state_e` enum {INIT, IDLE, ISSUE, RESP}.
- Sub-module `rr_arbiter`:
  - Combinational, parameterised by NUM_REQ.
  - Inputs: `req` vector, pointer.
  - Outputs: `found` flag, winner index.
- The top holds the FSM, pointer, captured op/index/value registers, and output decode.

## Test plan
- Reset release with no requests → one cycle `clear`=1; the datapath then reads 0; `gnt`/`rsp_valid` stay 0 indefinitely.
- `req[2]`=1 with op=incr, from count 5 → `gnt`=4'b0100 at n+1 with `plus`=1; at n+2, `rsp_valid`=1, `rsp_id`=2, `rsp_value`=6, `rsp_wrap`=0.
- All four `req` held high with op=incr from count 0 → grants in order 0,1,2,3,0 every 3 cycles; `rsp_value` reads 1,2,3,4,5.
- 16 increments from count 15 to 0 → the first response has `rsp_value`=0 and `rsp_wrap`=1; all later responses have `rsp_wrap`=0.
- `req[1]` clear at count 9 → `clear`=1 in ISSUE, `rsp_value`=0, `rsp_wrap`=0; `clear` and `plus` are never both 1 (assertion throughout).
- `reset` pulsed during RESP → no `rsp_valid` that cycle; INIT clear is issued; the next grant goes to the lowest pending index.
